ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_VEC, default 64'h0000_0000_0000_0000: PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 imem_addr  output  64  fetch address, driven combinationally from the PC register.
REQ-005 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-006 imem_exc_en / imem_exc_code / imem_exc_val  input  1/4/64  access-fault report for imem_addr.
REQ-007 redirect_en  input  1  branch/trap redirect request.
REQ-008 redirect_pc  input  64  redirect target.
REQ-009 out_valid  output  1  head entry present for decode.
REQ-010 out_ready  input  1  decode accepts head entry.
REQ-011 out_pc / out_instr  output  64/32  head entry PC and instruction.
REQ-012 out_exc_en / out_exc_code / out_exc_val  output  1/4/64  head entry exception fields.

Function
REQ-013 Block SHALL contain a 64-bit PC register, a 2-entry FIFO of {pc, instr, exc_en, exc_code, exc_val}, a 2-bit count, and a state FSM {RUN, HALT}.
REQ-014 Push condition: state==RUN && count<2 (count before any same-cycle pop) && !redirect_en; a pushed entry captures {PC, imem_instr, imem_exc_*}.
REQ-015 On push, PC SHALL advance by 64'd4; wrap-around from 64'hFFFF_FFFF_FFFF_FFFC to 0 is modular, no special handling.
REQ-016 If the pushed entry has exc_en=1, its instr field SHALL be 32'h00000013, PC SHALL NOT advance, and the FSM SHALL enter HALT.
REQ-017 In HALT no push occurs; HALT exits only on redirect_en or rst.
REQ-018 Pop condition: out_valid && out_ready; head advances one entry; push and pop in the same cycle SHALL both take effect (count unchanged).
REQ-019 Full (count==2) with simultaneous pop: pop taken, no push that cycle; push resumes next cycle.
REQ-020 redirect_en SHALL have priority over push and pop: FIFO flushed (count=0), PC<=redirect_pc, FSM<=RUN, no entry consumed or pushed that cycle.
REQ-021 out_valid = (count!=0); out_* reflect the head entry with zero latency from the FIFO registers.
REQ-022 When out_valid=0: out_pc=0, out_instr=32'h00000013, out_exc_en=0, out_exc_code=0, out_exc_val=0.
REQ-023 Fetch-to-decode latency: instruction at PC is visible on out_* one cycle after the push edge if FIFO was empty.

Reset
REQ-024 On rst: PC=RESET_VEC, count=0, FIFO head/tail pointers=0, FSM=RUN, all out_* at REQ-022 idle values.
REQ-025 rst SHALL override redirect_en, push and pop in the same cycle; mid-operation reset discards all buffered entries.

Configuration
REQ-026 Macro IFETCH_MISALIGN_CHK_EN: when defined, PC[1:0]!=0 at push SHALL push exc_en=1, exc_code=4'd0 (instruction address misaligned), exc_val=PC, instr=NOP, and enter HALT, ignoring imem_exc_*.
REQ-027 When IFETCH_MISALIGN_CHK_EN is undefined, PC[1:0] SHALL be forwarded unchecked and only imem_exc_* produces exceptions.

Structure
REQ-028 Shared package SHALL hold: NOP encoding 32'h00000013, exception codes (0 misaligned, 1 access fault), PC increment constant 4, FSM state enum.
REQ-029 The 2-entry FIFO SHALL be a sub-module fetch_fifo (parameterised width, depth 2, push/pop/flush, full/empty).

Verification
REQ-030 Reset with RESET_VEC=64'h0, out_ready=1, imem returns 32'h00500093 -> cycle 1 out_valid=1, out_pc=0; next out_pc=4, 8, ... one per cycle.
REQ-031 out_ready=0 for 5 cycles from reset -> count saturates at 2, imem_addr holds 64'h8, out_pc stays 0; release -> out_pc 0, 4, 8 consecutively.
REQ-032 imem_exc_en=1, code 1, val 64'h40000 at PC 64'h40000 -> entry with out_exc_en=1, out_exc_code=1, out_exc_val=64'h40000, out_instr=NOP; no further pushes until redirect.
REQ-033 From HALT, redirect_en=1, redirect_pc=64'h100 with FIFO full -> next cycle out_valid=0, imem_addr=64'h100; following cycle out_pc=64'h100.
REQ-034 With IFETCH_MISALIGN_CHK_EN, redirect_pc=64'h102 -> entry out_exc_en=1, out_exc_code=0, out_exc_val=64'h102; without macro -> normal fetch at 64'h102.
REQ-035 rst asserted while count=2 and redirect_en=1 -> next cycle count=0, imem_addr=RESET_VEC, out_valid=0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding,
// exception codes, PC step, FSM states and the buffered entry layout.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h00000013;
    localparam logic [3:0]  EXC_MISALIGN = 4'd0;
    localparam logic [3:0]  EXC_ACCESS   = 4'd1;
    localparam logic [63:0] PC_INC       = 64'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// fetch_fifo: two-entry FIFO with push, pop and flush, reporting full/empty.
// Push while full and pop while empty are ignored.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[head];

    // Storage write; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[tail] <= din;
        end
    end

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= ~tail;
            end
            if (do_pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ifetch.sv
// ifetch: PC generation, instruction capture into a 2-entry buffer and
// handoff to decode. Halts on a fetch exception until redirected.
// Optional macro IFETCH_MISALIGN_CHK_EN raises a misaligned-address
// exception when PC[1:0] != 0 at push time.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_VEC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    fetch_state_t     state;
    logic [63:0]      pc;
    fetch_entry_t     new_entry;
    fetch_entry_t     head_entry;
    logic [ENTRY_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign imem_addr = pc;

    // Push uses occupancy before any same-cycle pop, so a full buffer
    // drains one entry before fetch resumes.
    assign push = (state == ST_RUN) && !fifo_full && !redirect_en;
    assign pop  = !fifo_empty && out_ready && !redirect_en;

    // Build the entry captured on push, substituting NOP for faulting fetches.
    always_comb begin
        new_entry.pc       = pc;
        new_entry.instr    = imem_instr;
        new_entry.exc_en   = imem_exc_en;
        new_entry.exc_code = imem_exc_code;
        new_entry.exc_val  = imem_exc_val;
`ifdef IFETCH_MISALIGN_CHK_EN
        if (pc[1:0] != 2'b00) begin
            new_entry.exc_en   = 1'b1;
            new_entry.exc_code = EXC_MISALIGN;
            new_entry.exc_val  = pc;
        end
`endif
        if (new_entry.exc_en) begin
            new_entry.instr = NOP_INSTR;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_en),
        .push  (push),
        .pop   (pop),
        .din   (new_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // PC and RUN/HALT control; reset beats redirect, redirect beats push.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VEC;
            state <= ST_RUN;
        end else if (redirect_en) begin
            pc    <= redirect_pc;
            state <= ST_RUN;
        end else if (push) begin
            if (new_entry.exc_en) begin
                state <= ST_HALT;
            end else begin
                pc <= pc + PC_INC;
            end
        end
    end

    // Present the head entry, or idle values when the buffer is empty.
    always_comb begin
        head_entry   = fetch_entry_t'(fifo_dout);
        out_valid    = !fifo_empty;
        out_pc       = '0;
        out_instr    = NOP_INSTR;
        out_exc_en   = 1'b0;
        out_exc_code = '0;
        out_exc_val  = '0;
        if (!fifo_empty) begin
            out_pc       = head_entry.pc;
            out_instr    = head_entry.instr;
            out_exc_en   = head_entry.exc_en;
            out_exc_code = head_entry.exc_code;
            out_exc_val  = head_entry.exc_val;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, streaming, backpressure, fetch
// exception/halt, redirect, wrap-around, misalignment and reset priority.
module tb_ifetch;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADDI = 32'h00500093;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    logic        exc_arm;
    logic [63:0] exc_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: fixed instruction, access fault at one address.
    assign imem_instr    = ADDI;
    assign imem_exc_en   = exc_arm && (imem_addr == exc_addr);
    assign imem_exc_code = imem_exc_en ? 4'd1 : 4'd0;
    assign imem_exc_val  = imem_exc_en ? imem_addr : 64'd0;

    ifetch #(
        .RESET_VEC (64'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .imem_exc_en   (imem_exc_en),
        .imem_exc_code (imem_exc_code),
        .imem_exc_val  (imem_exc_val),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_exc_en    (out_exc_en),
        .out_exc_code  (out_exc_code),
        .out_exc_val   (out_exc_val)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 64'h0;
        exc_arm = 1'b0;
        exc_addr = 64'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp %h", out_valid, 1'b0); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", out_pc, 64'h0); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", out_instr, NOP); end
        checks++; if (out_exc_en !== 1'b0 || out_exc_code !== 4'd0 || out_exc_val !== 64'h0) begin
            errors++; $display("FAIL reset_exc got %h/%h/%h exp 0/0/0", out_exc_en, out_exc_code, out_exc_val); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 64'h0); end
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc;
        out_ready = 1'b1;
        do_reset();
        exp_pc = 64'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
                errors++; $display("FAIL stream_pc[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, exp_pc); end
            checks++; if (out_instr !== ADDI) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, out_instr, ADDI); end
            checks++; if (imem_addr !== exp_pc + 64'd4) begin
                errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, imem_addr, exp_pc + 64'd4); end
            exp_pc = exp_pc + 64'd4;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL bp_addr_hold got %h exp %h", imem_addr, 64'h8); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
            errors++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
        out_ready = 1'b1;
        step();
        checks++; if (out_pc !== 64'h4) begin errors++; $display("FAIL bp_release1 got %h exp %h", out_pc, 64'h4); end
        checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL bp_nopush_full got %h exp %h", imem_addr, 64'h8); end
        step();
        checks++; if (out_pc !== 64'h8) begin errors++; $display("FAIL bp_release2 got %h exp %h", out_pc, 64'h8); end
        checks++; if (imem_addr !== 64'hC) begin errors++; $display("FAIL bp_resume got %h exp %h", imem_addr, 64'hC); end
    endtask

    task automatic test_exception();
        out_ready = 1'b0;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 64'h40000;
        step();
        redirect_en = 1'b0;
        exc_arm = 1'b1;
        exc_addr = 64'h40000;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h40000) begin
            errors++; $display("FAIL exc_head got v=%b pc=%h exp v=1 pc=40000", out_valid, out_pc); end
        checks++; if (out_exc_en !== 1'b1 || out_exc_code !== 4'd1 || out_exc_val !== 64'h40000) begin
            errors++; $display("FAIL exc_fields got %h/%h/%h exp 1/1/40000", out_exc_en, out_exc_code, out_exc_val); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL exc_instr got %h exp %h", out_instr, NOP); end
        step();
        step();
        checks++; if (imem_addr !== 64'h40000) begin errors++; $display("FAIL exc_pc_hold got %h exp %h", imem_addr, 64'h40000); end
        exc_arm = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exc_halt_nopush got %b exp %b", out_valid, 1'b0); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exc_halt_stays got %b exp %b", out_valid, 1'b0); end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 64'h3FFFC;
        step();
        redirect_en = 1'b0;
        exc_arm = 1'b1;
        exc_addr = 64'h40000;
        step();
        step();
        step();
        checks++; if (out_pc !== 64'h3FFFC || out_exc_en !== 1'b0) begin
            errors++; $display("FAIL rdf_head got pc=%h exc=%b exp pc=3fffc exc=0", out_pc, out_exc_en); end
        checks++; if (imem_addr !== 64'h40000) begin errors++; $display("FAIL rdf_halt_addr got %h exp %h", imem_addr, 64'h40000); end
        exc_arm = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h100;
        out_ready = 1'b1;
        step();
        redirect_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdf_flush got %b exp %b", out_valid, 1'b0); end
        checks++; if (imem_addr !== 64'h100) begin errors++; $display("FAIL rdf_addr got %h exp %h", imem_addr, 64'h100); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== ADDI) begin
            errors++; $display("FAIL rdf_refetch got v=%b pc=%h i=%h exp v=1 pc=100 i=%h", out_valid, out_pc, out_instr, ADDI); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_en = 1'b0;
        step();
        checks++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++; $display("FAIL wrap_head got %h exp %h", out_pc, 64'hFFFF_FFFF_FFFF_FFFC); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr got %h exp %h", imem_addr, 64'h0); end
    endtask

    task automatic test_misalign();
        out_ready = 1'b0;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 64'h102;
        step();
        redirect_en = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h102) begin
            errors++; $display("FAIL mis_head got v=%b pc=%h exp v=1 pc=102", out_valid, out_pc); end
`ifdef IFETCH_MISALIGN_CHK_EN
        checks++; if (out_exc_en !== 1'b1 || out_exc_code !== 4'd0 || out_exc_val !== 64'h102 || out_instr !== NOP) begin
            errors++; $display("FAIL mis_exc got %h/%h/%h/%h exp 1/0/102/%h", out_exc_en, out_exc_code, out_exc_val, out_instr, NOP); end
        checks++; if (imem_addr !== 64'h102) begin errors++; $display("FAIL mis_halt got %h exp %h", imem_addr, 64'h102); end
`else
        checks++; if (out_exc_en !== 1'b0 || out_instr !== ADDI) begin
            errors++; $display("FAIL mis_noexc got %h/%h exp 0/%h", out_exc_en, out_instr, ADDI); end
        checks++; if (imem_addr !== 64'h106) begin errors++; $display("FAIL mis_advance got %h exp %h", imem_addr, 64'h106); end
`endif
    endtask

    task automatic test_reset_override();
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL rov_full got %h exp %h", imem_addr, 64'h8); end
        rst = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 64'h500;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        redirect_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rov_valid got %b exp %b", out_valid, 1'b0); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rov_addr got %h exp %h", imem_addr, 64'h0); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
            errors++; $display("FAIL rov_restart got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 64'h0;
        exc_arm = 1'b0;
        exc_addr = 64'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_exception();
        test_redirect_full();
        test_wrap();
        test_misalign();
        test_reset_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
